// File: rtl/irq_prio_arbiter_if.sv
// Request/grant bundle between the peripheral request lines, the core and irq_prio_arbiter.
// The master side drives requests, enables and acknowledge; the slave (arbiter) returns grant and status.
interface irq_prio_arbiter_if #(
  parameter int NUM_BUS    = 3,
  parameter int CH_PER_BUS = 9
);
  localparam int NUM_IRQ = NUM_BUS * CH_PER_BUS;
  localparam int BUS_W   = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
  localparam int CH_W    = (CH_PER_BUS > 1) ? $clog2(CH_PER_BUS) : 1;

  logic [NUM_IRQ-1:0]    req_i;
  logic [CH_PER_BUS-1:0] en_i;
  logic                  ack_i;
  logic                  irq_o;
  logic [BUS_W-1:0]      bus_o;
  logic [CH_W-1:0]       chan_o;
  logic [NUM_IRQ-1:0]    pend_o;

  modport master (output req_i, en_i, ack_i, input irq_o, bus_o, chan_o, pend_o);
  modport slave  (input req_i, en_i, ack_i, output irq_o, bus_o, chan_o, pend_o);
endinterface

// File: rtl/irq_prio_arbiter.sv
// Multi-bus interrupt priority controller: sticky pending bits, fixed bus priority, registered grant with ack handshake.
// Define IRQ_PRIO_RR_EN to rotate the in-bus channel priority with a per-bus round-robin pointer.
module irq_prio_arbiter #(
  parameter int NUM_BUS    = 3,
  parameter int CH_PER_BUS = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  irq_prio_arbiter_if.slave bus_if
);
  localparam int NUM_IRQ = NUM_BUS * CH_PER_BUS;
  localparam int BUS_W   = (NUM_BUS > 1) ? $clog2(NUM_BUS) : 1;
  localparam int CH_W    = (CH_PER_BUS > 1) ? $clog2(CH_PER_BUS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_IRQ-1:0] pend_q, pend_d;
  logic [NUM_IRQ-1:0] elig, clr;
  logic               irq_q, irq_d;
  logic [BUS_W-1:0]   bus_q, bus_d, win_bus;
  logic [CH_W-1:0]    chan_q, chan_d, win_chan;
  logic               win_vld;
  logic               ack_grant;

  assign elig      = pend_q & {NUM_BUS{bus_if.en_i}};
  assign ack_grant = (state_q == ST_GRANT) && bus_if.ack_i;

`ifdef IRQ_PRIO_RR_EN
  logic [CH_W-1:0] rr_q [NUM_BUS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BUS; b++) rr_q[b] <= '0;
    end else if (ack_grant) begin
      rr_q[bus_q] <= (chan_q == CH_W'(CH_PER_BUS - 1)) ? '0 : chan_q + CH_W'(1);
    end
  end
`endif

  // Lowest eligible bus wins; inside it the search starts at the rotation base and
  // runs downward so the candidate closest to the base is the last one written.
  always_comb begin
    int base;
    int c;
    win_vld  = 1'b0;
    win_bus  = '0;
    win_chan = '0;
    base     = 0;
    c        = 0;
    for (int b = 0; b < NUM_BUS; b++) begin
      if (!win_vld && |elig[b*CH_PER_BUS +: CH_PER_BUS]) begin
        win_vld = 1'b1;
        win_bus = BUS_W'(b);
`ifdef IRQ_PRIO_RR_EN
        base = int'(rr_q[b]);
`else
        base = 0;
`endif
        for (int k = CH_PER_BUS - 1; k >= 0; k--) begin
          c = base + k;
          if (c >= CH_PER_BUS) c = c - CH_PER_BUS;
          if (elig[b*CH_PER_BUS + c]) win_chan = CH_W'(c);
        end
      end
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    bus_d   = bus_q;
    chan_d  = chan_q;
    clr     = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          state_d = ST_GRANT;
          irq_d   = 1'b1;
          bus_d   = win_bus;
          chan_d  = win_chan;
        end
      end
      ST_GRANT: begin
        if (bus_if.ack_i) begin
          state_d = ST_GAP;
          irq_d   = 1'b0;
          clr[int'(bus_q)*CH_PER_BUS + int'(chan_q)] = 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A request still high in the ack cycle re-sets the bit it would have cleared.
    pend_d = (pend_q & ~clr) | bus_if.req_i;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      bus_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      bus_q   <= bus_d;
      chan_q  <= chan_d;
    end
  end

  assign bus_if.irq_o  = irq_q;
  assign bus_if.bus_o  = bus_q;
  assign bus_if.chan_o = chan_q;
  assign bus_if.pend_o = pend_q;
endmodule

// File: tb/tb_irq_prio_arbiter.sv
// Self-checking bench for irq_prio_arbiter: directed scenarios followed by random traffic,
// all compared each cycle against a flat-index pending/grant model.
module tb_irq_prio_arbiter;
  localparam int NB = 3;
  localparam int NC = 9;
  localparam int NI = NB * NC;

  logic clk = 1'b0;
  logic rst_n;
  logic [NI-1:0] req;
  logic [NC-1:0] en;
  logic          ack;

  int checks   = 0;
  int failures = 0;

  // reference model state
  bit [NI-1:0] m_pend;
  bit          m_irq;
  int          m_bus, m_chan;
  int          m_cool;
  int          m_rr [NB];

  irq_prio_arbiter_if #(.NUM_BUS(NB), .CH_PER_BUS(NC)) bif ();

  assign bif.req_i = req;
  assign bif.en_i  = en;
  assign bif.ack_i = ack;

  irq_prio_arbiter #(.NUM_BUS(NB), .CH_PER_BUS(NC)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = '0;
    m_irq  = 1'b0;
    m_bus  = 0;
    m_chan = 0;
    m_cool = 0;
    for (int b = 0; b < NB; b++) m_rr[b] = 0;
  endtask

  // One rising edge of the specified behaviour, using inputs as they stand at the edge.
  task automatic model_edge();
    int clr_idx = -1;
    int win     = -1;
    int c;
    if (m_irq) begin
      if (ack) begin
        clr_idx = m_bus * NC + m_chan;
        m_irq   = 1'b0;
        m_cool  = 1;
        m_rr[m_bus] = (m_chan + 1) % NC;
      end
    end else if (m_cool != 0) begin
      m_cool = 0;
    end else begin
`ifdef IRQ_PRIO_RR_EN
      for (int b = NB - 1; b >= 0; b--)
        for (int k = NC - 1; k >= 0; k--) begin
          c = (m_rr[b] + k) % NC;
          if (m_pend[b*NC + c] && en[c]) win = b * NC + c;
        end
`else
      for (int i = NI - 1; i >= 0; i--)
        if (m_pend[i] && en[i % NC]) win = i;
`endif
      if (win >= 0) begin
        m_irq  = 1'b1;
        m_bus  = win / NC;
        m_chan = win % NC;
      end
    end
    for (int i = 0; i < NI; i++) m_pend[i] = (m_pend[i] && i != clr_idx) || req[i];
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("irq",  32'(bif.irq_o),  32'(m_irq));
    check("bus",  32'(bif.bus_o),  32'(m_bus));
    check("chan", 32'(bif.chan_o), 32'(m_chan));
    check("pend", 32'(bif.pend_o), 32'(m_pend));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack_and_settle();
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ticks(2);
  endtask

  initial begin
    int exp6 [3];
    int n;
`ifdef IRQ_PRIO_RR_EN
    exp6[0] = 1; exp6[1] = 2; exp6[2] = 1;
`else
    exp6[0] = 1; exp6[1] = 1; exp6[2] = 1;
`endif
    rst_n = 1'b0;
    req   = '0;
    en    = '0;
    ack   = 1'b0;
    model_reset();
    #3;
    check("rst_irq",  32'(bif.irq_o),  0);
    check("rst_bus",  32'(bif.bus_o),  0);
    check("rst_chan", 32'(bif.chan_o), 0);
    check("rst_pend", 32'(bif.pend_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 1: single-cycle pulse on bus1 ch3
    en = 9'h1FF;
    req[12] = 1'b1;
    tick();
    check("s1_no_irq_yet", 32'(bif.irq_o), 0);
    req = '0;
    tick();
    check("s1_irq",  32'(bif.irq_o), 1);
    check("s1_bus",  32'(bif.bus_o), 1);
    check("s1_chan", 32'(bif.chan_o), 3);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("s1_pend_clr", 32'(bif.pend_o), 0);
    tick();
    check("s1_gap1", 32'(bif.irq_o), 0);
    tick();
    check("s1_gap2", 32'(bif.irq_o), 0);

    // 2: bus priority, bus0 ch5 ahead of bus2 ch2
    req[20] = 1'b1;
    req[5]  = 1'b1;
    ticks(2);
    check("s2_first_bus",  32'(bif.bus_o), 0);
    check("s2_first_chan", 32'(bif.chan_o), 5);
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ticks(2);
    check("s2_second_irq",  32'(bif.irq_o), 1);
    check("s2_second_bus",  32'(bif.bus_o), 2);
    check("s2_second_chan", 32'(bif.chan_o), 2);
    ack_and_settle();

    // 3: disabled channel stays pending and wins once enabled
    en = 9'h1F7;
    req[3] = 1'b1;
    req[4] = 1'b1;
    tick();
    req = '0;
    tick();
    check("s3_chan4", 32'(bif.chan_o), 4);
    ack_and_settle();
    ticks(3);
    check("s3_masked_irq",  32'(bif.irq_o), 0);
    check("s3_masked_pend", 32'(bif.pend_o), 32'h8);
    en = 9'h1FF;
    tick();
    check("s3_en_irq",  32'(bif.irq_o), 1);
    check("s3_en_chan", 32'(bif.chan_o), 3);
    ack_and_settle();

    // 4: no preemption during GRANT
    req[18] = 1'b1;
    tick();
    req = '0;
    tick();
    check("s4_bus2", 32'(bif.bus_o), 2);
    req[0] = 1'b1;
    ticks(2);
    check("s4_hold_bus",  32'(bif.bus_o), 2);
    check("s4_hold_chan", 32'(bif.chan_o), 0);
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    ticks(2);
    check("s4_next_irq", 32'(bif.irq_o), 1);
    check("s4_next_bus", 32'(bif.bus_o), 0);
    ack_and_settle();

    // 5: set wins over clear, then asynchronous reset mid-GRANT
    req[7] = 1'b1;
    ticks(2);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    check("s5_still_pend", 32'(bif.pend_o[7]), 1);
    ticks(2);
    check("s5_regrant_irq",  32'(bif.irq_o), 1);
    check("s5_regrant_chan", 32'(bif.chan_o), 7);
    #2;
    rst_n = 1'b0;
    #1;
    check("s5_async_irq",  32'(bif.irq_o), 0);
    check("s5_async_pend", 32'(bif.pend_o), 0);
    check("s5_async_chan", 32'(bif.chan_o), 0);
    model_reset();
    @(posedge clk);
    #1;
    check("s5_in_rst_pend", 32'(bif.pend_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("s5_repend", 32'(bif.pend_o), 32'h80);
    req = '0;
    tick();
    ack_and_settle();

    // 6: two held channels on bus0
    req[1] = 1'b1;
    req[2] = 1'b1;
    for (int g = 0; g < 3; g++) begin
      n = 0;
      while (bif.irq_o !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      check("s6_grant_seen", 32'(bif.irq_o), 1);
      check("s6_chan", 32'(bif.chan_o), 32'(exp6[g]));
      ack = 1'b1;
      tick();
      ack = 1'b0;
    end
    req = '0;
    ticks(4);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req = NI'($urandom & $urandom & $urandom);
      en  = NC'($urandom | $urandom);
      ack = ($urandom_range(0, 2) == 0);
      if (i == 200) begin
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rnd_rst_irq",  32'(bif.irq_o), 0);
        check("rnd_rst_pend", 32'(bif.pend_o), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
      tick();
    end
    req = '0;
    ack = 1'b0;
    ticks(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
